// File: rtl/tmu2_hinterp_multi_if.sv
// Span descriptor and output point bus for the horizontal span interpolator.
// Latency/backpressure: none of its own; it only carries the two valid/ack handshakes.
// Ports: slave = interpolator side, master = descriptor source / point sink side.
//   Optional clip_w exists only when TMU2_HINTERP_MULTI_CLIP_EN is defined.
interface tmu2_hinterp_multi_if #(
   parameter int CW  = 12,
   parameter int TW  = 18,
   parameter int NCH = 2,
   parameter int SW  = 11
);
   // descriptor side
   logic                    pipe_stb_i;
   logic                    pipe_ack_o;
   logic [CW-1:0]           x;
   logic [CW-1:0]           y;
   logic [SW-1:0]           dst_squarew;
   logic [NCH*TW-1:0]       init;
   logic [NCH-1:0]          positive;
   logic [NCH*(TW-1)-1:0]   q;
   logic [NCH*SW-1:0]       r;
   // point side
   logic                    pipe_stb_o;
   logic                    pipe_ack_i;
   logic [CW-1:0]           dx;
   logic [CW-1:0]           dy;
   logic [NCH*TW-1:0]       o;
`ifdef TMU2_HINTERP_MULTI_CLIP_EN
   logic [CW-2:0]           clip_w;

   modport slave (
      input  pipe_stb_i, x, y, dst_squarew, init, positive, q, r, pipe_ack_i, clip_w,
      output pipe_ack_o, pipe_stb_o, dx, dy, o
   );
   modport master (
      output pipe_stb_i, x, y, dst_squarew, init, positive, q, r, pipe_ack_i, clip_w,
      input  pipe_ack_o, pipe_stb_o, dx, dy, o
   );
`else
   modport slave (
      input  pipe_stb_i, x, y, dst_squarew, init, positive, q, r, pipe_ack_i,
      output pipe_ack_o, pipe_stb_o, dx, dy, o
   );
   modport master (
      output pipe_stb_i, x, y, dst_squarew, init, positive, q, r, pipe_ack_i,
      input  pipe_ack_o, pipe_stb_o, dx, dy, o
   );
`endif
endinterface

// File: rtl/tmu2_hinterp_multi.sv
// Horizontal span interpolator: one descriptor in, dst_squarew points out, NCH Bresenham channels.
// Latency: first point valid the cycle after the load handshake; one point per cycle under ack.
// Backpressure: point held stable until pipe_ack_i; no descriptor accepted while a span is active.
// Ports: sys_clk, sys_rst (sync, active-high), busy, pipe (slave modport of tmu2_hinterp_multi_if).
// Option TMU2_HINTERP_MULTI_CLIP_EN: points with dx outside [0, clip_w) are suppressed and
//   advance on their own so every channel stays aligned with dx.
module tmu2_hinterp_multi #(
   parameter int CW  = 12,
   parameter int TW  = 18,
   parameter int NCH = 2,
   parameter int SW  = 11
) (
   input  logic sys_clk,
   input  logic sys_rst,
   output logic busy,
   tmu2_hinterp_multi_if.slave pipe
);
   typedef enum logic {IDLE, BUSY} state_t;

   state_t                  state, state_n;
   logic [CW-1:0]           dx_r, dy_r;
   logic [NCH*TW-1:0]       o_r;
   logic [SW-1:0]           err [NCH];
   logic [SW-1:0]           remaining;
   logic [SW-1:0]           divisor;
   logic [NCH-1:0]          pos_l;
   logic [NCH*(TW-1)-1:0]   q_l;
   logic [NCH*SW-1:0]       r_l;

   logic                    load, step, visible;
   logic [SW:0]             s [NCH];
   logic [NCH-1:0]          carry;
   logic [SW-1:0]           err_n [NCH];
   logic [TW-1:0]           o_n [NCH];

   // control
   always_comb begin
      state_n         = state;
      load            = 1'b0;
      step            = 1'b0;
      busy            = (state == BUSY);
      pipe.pipe_ack_o = (state == IDLE);
`ifdef TMU2_HINTERP_MULTI_CLIP_EN
      // dx is signed: negative (msb set) is always off-screen
      visible = !dx_r[CW-1] && (dx_r[CW-2:0] < pipe.clip_w);
`else
      visible = 1'b1;
`endif
      pipe.pipe_stb_o = busy && visible;
      case (state)
         IDLE: begin
            // a zero-width descriptor is acked and dropped here
            if (pipe.pipe_stb_i && (pipe.dst_squarew != '0)) begin
               load    = 1'b1;
               state_n = BUSY;
            end
         end
         BUSY: begin
            // hidden points advance without waiting for the sink
            if (pipe.pipe_ack_i || !visible) begin
               if (remaining == '0) state_n = IDLE;
               else                 step    = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // per-channel step: err accumulates r modulo divisor, overflow carries one extra unit into o
   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         s[k]     = {1'b0, err[k]} + {1'b0, r_l[k*SW +: SW]};
         carry[k] = (s[k] >= {1'b0, divisor});
         err_n[k] = carry[k] ? SW'(s[k] - {1'b0, divisor}) : SW'(s[k]);
         if (pos_l[k])
            o_n[k] = o_r[k*TW +: TW] + {1'b0, q_l[k*(TW-1) +: TW-1]} + TW'(carry[k]);
         else
            o_n[k] = o_r[k*TW +: TW] - {1'b0, q_l[k*(TW-1) +: TW-1]} - TW'(carry[k]);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state     <= IDLE;
         dx_r      <= '0;
         dy_r      <= '0;
         o_r       <= '0;
         remaining <= '0;
         divisor   <= '0;
         pos_l     <= '0;
         q_l       <= '0;
         r_l       <= '0;
         for (int k = 0; k < NCH; k++) err[k] <= '0;
      end else begin
         state <= state_n;
         if (load) begin
            // whole descriptor is captured so the source may move on mid-span
            dx_r      <= pipe.x;
            dy_r      <= pipe.y;
            o_r       <= pipe.init;
            remaining <= pipe.dst_squarew - SW'(1);
            divisor   <= pipe.dst_squarew;
            pos_l     <= pipe.positive;
            q_l       <= pipe.q;
            r_l       <= pipe.r;
            for (int k = 0; k < NCH; k++) err[k] <= '0;
         end else if (step) begin
            dx_r      <= dx_r + CW'(1);
            remaining <= remaining - SW'(1);
            for (int k = 0; k < NCH; k++) begin
               err[k]            <= err_n[k];
               o_r[k*TW +: TW]   <= o_n[k];
            end
         end
      end
   end

   assign pipe.dx = dx_r;
   assign pipe.dy = dy_r;
   assign pipe.o  = o_r;
endmodule

// File: tb/tb_tmu2_hinterp_multi.sv
// Bench for tmu2_hinterp_multi: closed-form span model feeds an expected-point queue,
// a negedge process compares every presented point, directed cases pin literal values.
// Optional TMU2_HINTERP_MULTI_CLIP_EN adds the clipped-span case.
`timescale 1ns/1ps
module tb_tmu2_hinterp_multi;
   localparam int CW  = 12;
   localparam int TW  = 18;
   localparam int NCH = 2;
   localparam int SW  = 11;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   logic busy;

   always #5 sys_clk = ~sys_clk;

   tmu2_hinterp_multi_if #(.CW(CW), .TW(TW), .NCH(NCH), .SW(SW)) bus ();

   tmu2_hinterp_multi #(.CW(CW), .TW(TW), .NCH(NCH), .SW(SW)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .busy    (busy),
      .pipe    (bus)
   );

   typedef struct {
      logic [CW-1:0]     dx;
      logic [CW-1:0]     dy;
      logic [NCH*TW-1:0] o;
   } pt_t;

   pt_t exp_q[$];
   int  n_total = 0;
   int  n_pass  = 0;
   int  ack_mode = 0;
   int  ack_cnt  = 0;
   logic [CW-2:0] clip_val = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else n_pass++;
   endtask

   // Value of one channel after i steps: i*q plus the number of times the
   // running remainder i*r has wrapped past w.
   function automatic logic [TW-1:0] model_ch(input logic [TW-1:0] init0, input bit pos,
                                              input int unsigned qv, input int unsigned rv,
                                              input int unsigned w, input int unsigned i);
      longint unsigned delta;
      logic [63:0] d;
      delta = longint'(i) * qv + (longint'(i) * rv) / w;
      d = delta;
      return pos ? init0 + d[TW-1:0] : init0 - d[TW-1:0];
   endfunction

   // sink acknowledge pattern
   always @(posedge sys_clk) begin
      #1;
      case (ack_mode)
         0: bus.pipe_ack_i = 1'b1;
         1: begin bus.pipe_ack_i = (ack_cnt % 3 == 0); ack_cnt++; end
         default: bus.pipe_ack_i = 1'($urandom_range(0, 1));
      endcase
   end

   // compare every presented point with the head of the expected queue
   always @(negedge sys_clk) begin
      if (!sys_rst && bus.pipe_stb_o) begin
         if (exp_q.size() == 0) chk("unexpected_point", 64'd1, 64'd0);
         else begin
            chk("pt_dx", 64'(bus.dx), 64'(exp_q[0].dx));
            chk("pt_dy", 64'(bus.dy), 64'(exp_q[0].dy));
            chk("pt_o",  64'(bus.o),  64'(exp_q[0].o));
            if (bus.pipe_ack_i) void'(exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [CW-1:0] x, input logic [CW-1:0] y, input int unsigned w,
                       input logic [NCH*TW-1:0] iv, input logic [NCH-1:0] pv,
                       input logic [NCH*(TW-1)-1:0] qv, input logic [NCH*SW-1:0] rv);
      int n;
      n = 0;
      while (!bus.pipe_ack_o && n < 200) begin @(posedge sys_clk); #1; n++; end
      chk("accept_ready", 64'(bus.pipe_ack_o), 64'd1);
      bus.x = x; bus.y = y; bus.dst_squarew = SW'(w);
      bus.init = iv; bus.positive = pv; bus.q = qv; bus.r = rv;
      bus.pipe_stb_i = 1'b1;
      @(posedge sys_clk);
      for (int i = 0; i < int'(w); i++) begin
         pt_t p;
         bit  vis;
         p.dx = x + CW'(i);
         p.dy = y;
         for (int k = 0; k < NCH; k++)
            p.o[k*TW +: TW] = model_ch(iv[k*TW +: TW], pv[k], int'(qv[k*(TW-1) +: TW-1]),
                                       int'(rv[k*SW +: SW]), w, i);
`ifdef TMU2_HINTERP_MULTI_CLIP_EN
         vis = !p.dx[CW-1] && (int'(p.dx) < int'(clip_val));
`else
         vis = 1'b1;
`endif
         if (vis) exp_q.push_back(p);
      end
      #1 bus.pipe_stb_i = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < 500) begin @(posedge sys_clk); #1; n++; end
      chk({name, "_idle"}, 64'(busy), 64'd0);
      chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   logic [TW-1:0] lit_pos [4];
   logic [TW-1:0] lit_neg [4];
   logic [NCH*TW-1:0] iv;
   logic [NCH-1:0] pv;
   logic [NCH*(TW-1)-1:0] qv;
   logic [NCH*SW-1:0] rv;

   initial begin
      int acks, n, w;
      lit_pos = '{18'd100, 18'd102, 18'd105, 18'd108};
      lit_neg = '{18'd50, 18'd49, 18'd47, 18'd46};
      bus.pipe_stb_i = 1'b0; bus.pipe_ack_i = 1'b0;
      bus.x = '0; bus.y = '0; bus.dst_squarew = '0;
      bus.init = '0; bus.positive = '0; bus.q = '0; bus.r = '0;
`ifdef TMU2_HINTERP_MULTI_CLIP_EN
      clip_val = CW'(1) << (CW-2);
      bus.clip_w = clip_val;
`endif

      // reset state
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_stb_o", 64'(bus.pipe_stb_o), 64'd0);
      chk("rst_ack_o", 64'(bus.pipe_ack_o), 64'd1);
      chk("rst_dx", 64'(bus.dx), 64'd0);
      chk("rst_dy", 64'(bus.dy), 64'd0);
      chk("rst_o", 64'(bus.o), 64'd0);
      sys_rst = 1'b0;
      @(posedge sys_clk); #1;

      // model pinned against hand-derived values
      for (int i = 0; i < 4; i++) begin
         chk("model_pos", 64'(model_ch(18'd100, 1'b1, 2, 3, 4, i)), 64'(lit_pos[i]));
         chk("model_neg", 64'(model_ch(18'd50, 1'b0, 1, 2, 4, i)), 64'(lit_neg[i]));
      end

      // positive slope on ch0, negative slope on ch1, continuous ack
      ack_mode = 0;
      iv = {18'd50, 18'd100}; pv = 2'b01; qv = {17'd1, 17'd2}; rv = {11'd2, 11'd3};
      send(12'd10, 12'd5, 4, iv, pv, qv, rv);
      for (int i = 0; i < 4; i++) begin
         chk("pos_stb", 64'(bus.pipe_stb_o), 64'd1);
         chk("pos_dx", 64'(bus.dx), 64'(10 + i));
         chk("pos_dy", 64'(bus.dy), 64'd5);
         chk("pos_o0", 64'(bus.o[0 +: TW]), 64'(lit_pos[i]));
         chk("neg_o1", 64'(bus.o[TW +: TW]), 64'(lit_neg[i]));
         @(posedge sys_clk); #1;
      end
      chk("pos_end_busy", 64'(busy), 64'd0);
      chk("pos_end_ack_o", 64'(bus.pipe_ack_o), 64'd1);
      wait_idle("pos");

      // backpressure: ack 1,0,0,1,...
      ack_cnt = 0; ack_mode = 1;
      send(12'd10, 12'd5, 4, iv, pv, qv, rv);
      acks = 0; n = 0;
      while (acks < 4 && n < 100) begin
         @(negedge sys_clk);
         if (bus.pipe_stb_o && bus.pipe_ack_i) begin
            acks++;
            if (acks == 4) chk("bp_busy_at_4th", 64'(busy), 64'd1);
         end
         n++;
      end
      chk("bp_ack_count", 64'(acks), 64'd4);
      @(posedge sys_clk); #1;
      chk("bp_busy_after_4th", 64'(busy), 64'd0);
      wait_idle("bp");
      ack_mode = 0;

      // zero width, then a descriptor straight after
      send(12'd3, 12'd3, 0, iv, pv, qv, rv);
      chk("zw_ack_o", 64'(bus.pipe_ack_o), 64'd1);
      chk("zw_busy", 64'(busy), 64'd0);
      send(12'd7, 12'd1, 2, iv, pv, qv, {11'd1, 11'd1});
      wait_idle("zw_next");

      // reset mid-span after the second point
      send(12'd20, 12'd9, 4, iv, pv, qv, rv);
      n = 0;
      while (exp_q.size() > 2 && n < 50) begin @(posedge sys_clk); #1; n++; end
      chk("mid_two_points", 64'(exp_q.size()), 64'd2);
      sys_rst = 1'b1;
      @(posedge sys_clk); #1;
      sys_rst = 1'b0;
      exp_q.delete();
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_stb_o", 64'(bus.pipe_stb_o), 64'd0);
      chk("mid_rst_dx", 64'(bus.dx), 64'd0);
      chk("mid_rst_o", 64'(bus.o), 64'd0);
      send(12'd30, 12'd2, 1, iv, pv, qv, '0);
      chk("w1_dx", 64'(bus.dx), 64'd30);
      wait_idle("w1");

`ifdef TMU2_HINTERP_MULTI_CLIP_EN
      // clipped span: only dx=0 and dx=1 visible
      clip_val = 11'd2; bus.clip_w = clip_val;
      send(-12'sd2, 12'd5, 5, iv, pv, qv, rv);
      chk("clip_model_points", 64'(exp_q.size()), 64'd2);
      n = 0;
      while (busy && n < 50) begin @(posedge sys_clk); #1; n++; end
      chk("clip_cycles", 64'(n), 64'd5);
      wait_idle("clip");
`endif

      // randomized spans with random sink stalls
      ack_mode = 2;
      for (int t = 0; t < 40; t++) begin
         w = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
         for (int k = 0; k < NCH; k++) begin
            iv[k*TW +: TW]         = TW'($urandom);
            pv[k]                  = 1'($urandom_range(0, 1));
            qv[k*(TW-1) +: TW-1]   = ($urandom_range(0, 1) == 1) ? (TW-1)'($urandom_range(0, 5))
                                                                 : (TW-1)'($urandom);
            rv[k*SW +: SW]         = (w > 0) ? SW'($urandom_range(0, w - 1)) : '0;
         end
`ifdef TMU2_HINTERP_MULTI_CLIP_EN
         clip_val = (CW-1)'($urandom_range(0, 12)); bus.clip_w = clip_val;
         send(CW'($urandom_range(0, 24)) - CW'(8), CW'($urandom), w, iv, pv, qv, rv);
`else
         send(CW'($urandom), CW'($urandom), w, iv, pv, qv, rv);
`endif
         wait_idle("rand");
      end

      chk("final_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/tmu2_hinterp_multi.md
Name: tmu2_hinterp_multi

Overview:
Parametrised horizontal span interpolator for the TMU2 pipeline, successor to the fixed two-channel 18-bit horizontal interpolator.
- Accepts one span descriptor per handshake: start point, span width, and NCH texture-coordinate channels, each with an init value and a quotient/remainder slope.
- Emits one point per accepted output beat, with integer Bresenham-style stepping per channel.
- Sits between the vertical interpolator/divider and the texel fetch stages.

Parameters:
CW, 12, signed destination coordinate width (x, y, dx, dy)
TW, 18, signed texture coordinate width per channel
NCH, 2, number of interpolated channels
SW, 11, span width / divisor width

Ports:
sys_clk  in  1  clock
sys_rst  in  1  synchronous active-high reset
busy  out  1  high while a span is in progress
pipe_stb_i  in  1  span descriptor valid
pipe_ack_o  out  1  descriptor accepted (equals ~busy)
x, y  in  CW each  signed span start point
dst_squarew  in  SW  span width in points (also the divisor)
init  in  NCH*TW  per-channel start value, channel k at [k*TW +: TW]
positive  in  NCH  per-channel slope sign
q  in  NCH*(TW-1)  per-channel slope quotient magnitude
r  in  NCH*SW  per-channel slope remainder; contract: r < dst_squarew
pipe_stb_o  out  1  output point valid
pipe_ack_i  in  1  downstream accepts point
dx, dy  out  CW each  signed current point
o  out  NCH*TW  per-channel current value

Behaviour:
- Single clock. Reset is synchronous and active-high on sys_rst. Reset values: state IDLE, busy=0, pipe_stb_o=0, pipe_ack_o=1, dx=dy=0, o=0, all error accumulators 0, remaining=0.
- FSM states: IDLE, BUSY.
- IDLE:
  - pipe_ack_o=1.
  - On pipe_stb_i with dst_squarew!=0: load dx<=x, dy<=y, o_k<=init_k, err_k<=0, remaining<=dst_squarew-1; go to BUSY.
  - On pipe_stb_i with dst_squarew==0: descriptor is consumed, no point is emitted, FSM stays IDLE.
- BUSY:
  - pipe_stb_o=1 (see the optional feature); outputs stay stable until acked.
  - On pipe_ack_i with remaining==0: go to IDLE.
  - On pipe_ack_i otherwise: step. dx<=dx+1, remaining<=remaining-1, every channel advances. dy is unchanged.
- Channel step, with s = err_k + r_k computed in SW+1 bits:
  - If s >= dst_squarew_latched: err_k <= s - divisor, carry=1.
  - Else: err_k <= s, carry=0.
  - positive: o_k <= o_k + q_k + carry. Otherwise: o_k <= o_k - q_k - carry.
  - All arithmetic wraps modulo 2^TW; dx wraps modulo 2^CW.
- dst_squarew is latched at load; later input changes have no effect mid-span.
- Latency: first point is valid the cycle after the load handshake. Throughput is one point per cycle under continuous ack.
- pipe_ack_i while pipe_stb_o=0 is ignored.
- A descriptor is never accepted while BUSY. The last-point ack and a new pipe_stb_i cannot overlap; a one-cycle IDLE bubble always separates spans.
- sys_rst mid-span abandons the span immediately; all state returns to its reset values on the next edge.
- r_k >= divisor is outside the contract; no checking is done.

Optional Feature:
TMU2_HINTERP_MULTI_CLIP_EN
- Defined: adds input clip_w (CW-1 bits, unsigned).
  - In BUSY, pipe_stb_o = (dx >= 0) && (dx < clip_w).
  - A point with pipe_stb_o=0 self-advances without ack (step or return to IDLE) one per cycle, so interpolators stay in sync.
  - A fully clipped span takes dst_squarew cycles and emits nothing.
- Undefined: no clip_w port; pipe_stb_o = busy state; no points are suppressed.

Test Plan:
- Positive slope: width=4, x=10, y=5, ch0 init=100, positive, q=2, r=3, continuous ack -> (dx,o0) = (10,100), (11,102), (12,105), (13,108); dy=5 throughout; then IDLE, ack_o=1.
- Negative slope: width=4, ch1 init=50, negative, q=1, r=2 -> o1 = 50, 49, 47, 46.
- Backpressure: same as the positive-slope case with pipe_ack_i toggling 1,0,0,1,... -> outputs hold while unacked; the same four values, no duplicates or skips; busy falls after the 4th ack.
- Zero width: dst_squarew=0 with pipe_stb_i -> ack_o=1, pipe_stb_o never asserts, FSM stays IDLE, next descriptor accepted next cycle.
- Reset mid-span: assert sys_rst after the 2nd point -> next cycle busy=0, pipe_stb_o=0, dx=0, o=0; a new width=1 span then emits a single point.
- Clip (macro defined): x=-2, width=5, clip_w=2 -> points at dx=0 and dx=1 only; o values match the unclipped sequence at those dx; IDLE 5 cycles after load with 2 acks.
